seg7_multi_ctrl: RTL
====================

# seg7_multi_ctrl

Parametrised multi-digit seven-segment display controller. It is the successor to the single-digit decoder with external blink: it drives DIGITS active-low seven-segment displays in parallel from a latched BCD/hex word. It adds an internal blink timebase, a per-digit blink mask, a hex mode and leading-zero blanking. It sits between the datapath result registers and the board display pins.

## Interface
Parameters:
- DIGITS, default 4: number of displays driven (1..8).
- BLINK_DIV, default 25000000: clock cycles per blink half-period (≥2).

Ports:
- clk  in  1: system clock, rising edge.
- rst_n  in  1: reset, asynchronous and active-low.
- load  in  1: when 1, capture `data` into the holding register this edge.
- data  in  4*DIGITS: nibble i (bits 4i+3:4i) is the value for digit i; digit 0 is least significant.
- hex_mode  in  1: 1 decodes 10..15 as A,b,C,d,E,F; 0 blanks 10..15.
- lzb  in  1: leading-zero blanking enable.
- blink_mask  in  DIGITS: bit i = 1 makes digit i blink.
- blink_rst  in  1: synchronous restart of the blink timebase.
- seg  out  7*DIGITS: digit i on bits 7i+6:7i, order {g,f,e,d,c,b,a}, active-low, registered.
- blink_phase  out  1: current blink phase; 1 = blinking digits dark.

## Operation
Holding register `data_q` (4*DIGITS):
- Reset value is 0.
- Loads `data` on an edge with load=1; otherwise holds.

Segment patterns (1 = segment off):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1011000, 8=0000000, 9=0010000.
- Hex mode only: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Values 10..15 with hex_mode=0 give blank (1111111).

Leading-zero blanking (lzb=1):
- Digit i is blanked when its nibble and every higher nibble of `data_q` are 0.
- Digit 0 is never blanked by lzb, so an all-zero word shows a single "0".
- A non-zero digit stops blanking for all digits below it. Example: 0x0105 shows "105".

Blink timebase:
- Counter `bcnt` runs 0..BLINK_DIV-1, incrementing every cycle.
- At BLINK_DIV-1 it wraps to 0 and blink_phase toggles.
- blink_rst=1 forces bcnt=0 and blink_phase=0 on that edge. This takes priority over wrap and toggle.

Per-digit output priority, highest first:
1. Blink: blink_phase=1 and blink_mask[i]=1 → blank.
2. Leading-zero blank.
3. Invalid decimal code → blank.
4. Decoded pattern.

Configuration inputs hex_mode, lzb and blink_mask are sampled every cycle and are not latched by load.

## Timing
- Reset assertion immediately (asynchronously) sets:
  - seg = all ones (every digit dark)
  - blink_phase = 0
  - bcnt = 0
  - data_q = 0
- Reset mid-operation discards the held value and the blink position.
- First edge after reset release: seg shows the decode of data_q=0 under the current hex_mode, lzb and mask.
- Load latency: load=1 at edge N updates data_q at edge N; seg reflects the new value at edge N+1.
- Config latency: a change to hex_mode, lzb or blink_mask appears on seg after 1 edge.
- blink_phase changes at the same edge bcnt wraps. seg reflects the new phase 1 edge later.
- Blink half-period is exactly BLINK_DIV cycles; full period is 2*BLINK_DIV.
- load and blink_rst in the same cycle are independent; both take effect.

## Test plan
- Reset: hold rst_n=0 mid-run → seg=all 1s and blink_phase=0 asynchronously. After release with lzb=0 and DIGITS=4 → seg = four copies of 1000000 after 1 edge.
- Decode sweep, DIGITS=4, lzb=0, mask=0: load each data 0x0000..0xFFFF nibble-uniform in both hex_mode settings → every pattern matches the table. 0xAAAA with hex_mode=0 → all 1111111.
- Leading-zero blanking: lzb=1. Load 0x0105 → digit3 blank, digit2=1, digit1=0, digit0=5. Load 0x0000 → digits 3..1 blank, digit0=0.
- Blink timing with BLINK_DIV=4, mask=4'b0010: blink_phase toggles every 4 cycles. Digit1 is dark for 4 cycles and lit for 4; other digits are never dark.
- Blink restart: assert blink_rst on the cycle bcnt=3 → blink_phase stays 0 and the next toggle occurs 4 cycles later.
- Load latency: load=1 with data=0x1234 at edge N → seg still shows the old value until edge N+1, then shows 1,2,3,4.

Source files
------------

// File: rtl/seg7_multi_ctrl.sv
// seg7_multi_ctrl: multi-digit active-low 7-seg driver with blink timebase, hex mode and leading-zero blanking
module seg7_multi_ctrl #(
  parameter int DIGITS    = 4,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [4*DIGITS-1:0] data,
  input  logic                hex_mode,
  input  logic                lzb,
  input  logic [DIGITS-1:0]   blink_mask,
  input  logic                blink_rst,
  output logic [7*DIGITS-1:0] seg,
  output logic                blink_phase
);
  localparam int CW = $clog2(BLINK_DIV);
  logic [4*DIGITS-1:0] r_data;
  logic [CW-1:0]       r_bcnt;
  logic                r_phase;
  logic [7*DIGITS-1:0] r_seg;
  logic [7*DIGITS-1:0] w_seg;
  logic                w_run;
  function automatic logic [6:0] dec(input logic [3:0] v, input logic hx);
    case (v)
      4'h0: dec = 7'b1000000;
      4'h1: dec = 7'b1111001;
      4'h2: dec = 7'b0100100;
      4'h3: dec = 7'b0110000;
      4'h4: dec = 7'b0011001;
      4'h5: dec = 7'b0010010;
      4'h6: dec = 7'b0000010;
      4'h7: dec = 7'b1011000;
      4'h8: dec = 7'b0000000;
      4'h9: dec = 7'b0010000;
      4'ha: dec = hx ? 7'b0001000 : 7'h7f;
      4'hb: dec = hx ? 7'b0000011 : 7'h7f;
      4'hc: dec = hx ? 7'b1000110 : 7'h7f;
      4'hd: dec = hx ? 7'b0100001 : 7'h7f;
      4'he: dec = hx ? 7'b0000110 : 7'h7f;
      default: dec = hx ? 7'b0001110 : 7'h7f;
    endcase
  endfunction
  // w_run stays high while every nibble from the top down to i is zero
  always_comb begin
    w_seg = '1;
    w_run = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_run = w_run && (r_data[4*i+:4] == 4'd0);
      w_seg[7*i+:7] = ((r_phase && blink_mask[i]) || (lzb && w_run && i != 0)) ? 7'h7f
                    : dec(r_data[4*i+:4], hex_mode);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_bcnt  <= '0;
      r_phase <= 1'b0;
      r_seg   <= '1;
    end else begin
      if (load) r_data <= data;
      r_seg <= w_seg;
      if (blink_rst) begin
        r_bcnt  <= '0;
        r_phase <= 1'b0;
      end else if (r_bcnt == CW'(BLINK_DIV - 1)) begin
        r_bcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_bcnt <= r_bcnt + CW'(1);
      end
    end
  end
  assign seg         = r_seg;
  assign blink_phase = r_phase;
endmodule
